// File: rtl/cf_math_pkg.sv
// Small math helpers shared across the cache and allocator blocks.
package cf_math_pkg;

    // Index width for a table of num_idx entries; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned num_idx);
        return (num_idx > 32'd1) ? unsigned'($clog2(num_idx)) : 32'd1;
    endfunction

endpackage

// File: rtl/iommu_alloc_pkg.sv
// Shared types and width helpers for the IOMMU cache slot allocator.
package iommu_alloc_pkg;

    localparam int unsigned NUM_SLOTS_DEFAULT = 8;
    localparam int unsigned IDX_W_DEFAULT     = cf_math_pkg::idx_width(NUM_SLOTS_DEFAULT);

    function automatic int unsigned alloc_idx_w(input int unsigned num_slots);
        return cf_math_pkg::idx_width(num_slots);
    endfunction

    // Bundled grant response for consumers that carry it as one signal.
    typedef struct packed {
        logic                     gnt;
        logic [IDX_W_DEFAULT-1:0] idx;
        logic                     evict;
    } alloc_rsp_t;

endpackage

// File: rtl/lzc.sv
// Leading/trailing zero counter; MODE=0 counts trailing zeros (lowest set bit).
module lzc #(
    parameter int unsigned WIDTH     = 2,
    parameter bit          MODE      = 1'b0,
    parameter int unsigned CNT_WIDTH = cf_math_pkg::idx_width(WIDTH)
) (
    input  logic [WIDTH-1:0]     in_i,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 empty_o
);

    always_comb begin
        cnt_o = '0;
        if (MODE == 1'b0) begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (in_i[i]) begin
                    cnt_o = CNT_WIDTH'(i);
                end
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (in_i[i]) begin
                    cnt_o = CNT_WIDTH'(WIDTH - 1 - i);
                end
            end
        end
    end

    assign empty_o = ~|in_i;

endmodule

// File: rtl/iommu_slot_alloc.sv
// Slot allocator for fully-associative IOMMU caches: lowest free slot first,
// round-robin victim once every slot is valid.
module iommu_slot_alloc
    import iommu_alloc_pkg::*;
#(
    parameter int unsigned NUM_SLOTS = 8,
    parameter int unsigned IDX_W     = alloc_idx_w(NUM_SLOTS)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 alloc_req_i,
    output logic                 alloc_gnt_o,
    output logic [IDX_W-1:0]     alloc_idx_o,
    output logic                 alloc_evict_o,
    input  logic                 free_i,
    input  logic [IDX_W-1:0]     free_idx_i,
    input  logic                 flush_i,
    output logic [NUM_SLOTS-1:0] valid_o,
    output logic                 full_o,
    output logic [IDX_W-1:0]     victim_o
);

    logic [NUM_SLOTS-1:0] valid_q, valid_d;
    logic [IDX_W-1:0]     victim_q, victim_d;
    logic [IDX_W-1:0]     free_slot;
    logic                 all_valid;

    lzc #(
        .WIDTH     (NUM_SLOTS),
        .MODE      (1'b0),
        .CNT_WIDTH (IDX_W)
    ) u_free_lzc (
        .in_i    (~valid_q),
        .cnt_o   (free_slot),
        .empty_o (all_valid)
    );

    // Grant is gated by reset so a held request is never granted while in reset.
    assign alloc_gnt_o   = alloc_req_i & ~flush_i & rst_ni;
    assign alloc_idx_o   = all_valid ? victim_q : free_slot;
    assign alloc_evict_o = all_valid & alloc_gnt_o;
    assign full_o        = all_valid;
    assign valid_o       = valid_q;
    assign victim_o      = victim_q;

    // Clear before set so a same-cycle free and alloc of one slot leaves it valid.
    always_comb begin
        valid_d = valid_q;
        if (flush_i) begin
            valid_d = '0;
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (free_i && (free_idx_i == IDX_W'(i))) begin
                    valid_d[i] = 1'b0;
                end
            end
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (alloc_gnt_o && (alloc_idx_o == IDX_W'(i))) begin
                    valid_d[i] = 1'b1;
                end
            end
        end
    end

    // Explicit wrap keeps the pointer inside non-power-of-two slot counts.
    always_comb begin
        victim_d = victim_q;
        if (alloc_evict_o) begin
            victim_d = (victim_q == IDX_W'(NUM_SLOTS - 1)) ? '0 : victim_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q  <= '0;
            victim_q <= '0;
        end else begin
            valid_q  <= valid_d;
            victim_q <= victim_d;
        end
    end

endmodule

// File: tb/tb_iommu_slot_alloc.sv
// Directed bench for iommu_slot_alloc with a 4-slot and a 5-slot instance.
module tb_iommu_slot_alloc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic       rst4 = 1'b0, req4 = 1'b0, free4 = 1'b0, flush4 = 1'b0;
    logic [1:0] free_idx4 = '0;
    logic       gnt4, evict4, full4;
    logic [1:0] idx4, victim4;
    logic [3:0] valid4;

    logic       rst5 = 1'b0, req5 = 1'b0, free5 = 1'b0, flush5 = 1'b0;
    logic [2:0] free_idx5 = '0;
    logic       gnt5, evict5, full5;
    logic [2:0] idx5, victim5;
    logic [4:0] valid5;

    iommu_slot_alloc #(.NUM_SLOTS(4)) dut4 (
        .clk_i(clk), .rst_ni(rst4), .alloc_req_i(req4), .alloc_gnt_o(gnt4),
        .alloc_idx_o(idx4), .alloc_evict_o(evict4), .free_i(free4),
        .free_idx_i(free_idx4), .flush_i(flush4), .valid_o(valid4),
        .full_o(full4), .victim_o(victim4)
    );

    iommu_slot_alloc #(.NUM_SLOTS(5)) dut5 (
        .clk_i(clk), .rst_ni(rst5), .alloc_req_i(req5), .alloc_gnt_o(gnt5),
        .alloc_idx_o(idx5), .alloc_evict_o(evict5), .free_i(free5),
        .free_idx_i(free_idx5), .flush_i(flush5), .valid_o(valid5),
        .full_o(full5), .victim_o(victim5)
    );

    always @(posedge clk) begin
        assert (!(free4 && free_idx4 > 2'd3)) else $error("free index out of range on 4-slot");
        assert (!(free5 && free_idx5 > 3'd4)) else $error("free index out of range on 5-slot");
    end

    task automatic drive4(input logic req, input logic fr, input logic [1:0] fidx, input logic fl);
        @(negedge clk);
        req4 = req; free4 = fr; free_idx4 = fidx; flush4 = fl;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst4 = 1'b0;
        req4 = 1'b1;
        #2;
        checks++;
        if ({gnt4, idx4, evict4, valid4, full4, victim4} !== 11'b0) begin
            errors++;
            $display("FAIL reset4 got gnt=%b idx=%0d ev=%b valid=%b full=%b victim=%0d want all 0",
                     gnt4, idx4, evict4, valid4, full4, victim4);
        end
        drive4(1'b0, 1'b0, 2'd0, 1'b0);
        rst4 = 1'b1;
        tick();
    endtask

    task automatic test_fill;
        logic [3:0] exp_valid;
        for (int i = 0; i < 4; i++) begin
            drive4(1'b1, 1'b0, 2'd0, 1'b0);
            checks++;
            if (gnt4 !== 1'b1 || idx4 !== 2'(i) || evict4 !== 1'b0) begin
                errors++;
                $display("FAIL fill_grant%0d got gnt=%b idx=%0d ev=%b want 1 %0d 0", i, gnt4, idx4, evict4, i);
            end
            tick();
            exp_valid = 4'((1 << (i + 1)) - 1);
            checks++;
            if (valid4 !== exp_valid) begin
                errors++;
                $display("FAIL fill_valid%0d got %b want %b", i, valid4, exp_valid);
            end
        end
        checks++;
        if (full4 !== 1'b1) begin
            errors++;
            $display("FAIL fill_full got %b want 1", full4);
        end
    endtask

    task automatic test_evict_wrap;
        logic [1:0] exp_victim;
        for (int i = 0; i < 4; i++) begin
            drive4(1'b1, 1'b0, 2'd0, 1'b0);
            checks++;
            if (gnt4 !== 1'b1 || idx4 !== 2'(i) || evict4 !== 1'b1) begin
                errors++;
                $display("FAIL evict_grant%0d got gnt=%b idx=%0d ev=%b want 1 %0d 1", i, gnt4, idx4, evict4, i);
            end
            tick();
            exp_victim = (i == 3) ? 2'd0 : 2'(i + 1);
            checks++;
            if (victim4 !== exp_victim || valid4 !== 4'b1111) begin
                errors++;
                $display("FAIL evict_victim%0d got victim=%0d valid=%b want %0d 1111", i, victim4, valid4, exp_victim);
            end
        end
    endtask

    task automatic test_free_then_alloc;
        drive4(1'b0, 1'b1, 2'd2, 1'b0);
        tick();
        checks++;
        if (valid4 !== 4'b1011 || full4 !== 1'b0) begin
            errors++;
            $display("FAIL free2 got valid=%b full=%b want 1011 0", valid4, full4);
        end
        drive4(1'b1, 1'b0, 2'd0, 1'b0);
        checks++;
        if (gnt4 !== 1'b1 || idx4 !== 2'd2 || evict4 !== 1'b0) begin
            errors++;
            $display("FAIL refill2 got gnt=%b idx=%0d ev=%b want 1 2 0", gnt4, idx4, evict4);
        end
        tick();
        checks++;
        if (valid4 !== 4'b1111 || victim4 !== 2'd0) begin
            errors++;
            $display("FAIL refill2_state got valid=%b victim=%0d want 1111 0", valid4, victim4);
        end
    endtask

    task automatic test_free_alloc_same_cycle;
        drive4(1'b1, 1'b1, 2'd1, 1'b0);
        checks++;
        if (gnt4 !== 1'b1 || idx4 !== 2'd0 || evict4 !== 1'b1) begin
            errors++;
            $display("FAIL full_free_alloc got gnt=%b idx=%0d ev=%b want 1 0 1", gnt4, idx4, evict4);
        end
        tick();
        checks++;
        if (valid4 !== 4'b1101 || victim4 !== 2'd1 || full4 !== 1'b0) begin
            errors++;
            $display("FAIL full_free_alloc_state got valid=%b victim=%0d full=%b want 1101 1 0",
                     valid4, victim4, full4);
        end
        drive4(1'b1, 1'b1, 2'd1, 1'b0);
        checks++;
        if (gnt4 !== 1'b1 || idx4 !== 2'd1 || evict4 !== 1'b0) begin
            errors++;
            $display("FAIL same_slot got gnt=%b idx=%0d ev=%b want 1 1 0", gnt4, idx4, evict4);
        end
        tick();
        checks++;
        if (valid4 !== 4'b1111 || victim4 !== 2'd1) begin
            errors++;
            $display("FAIL same_slot_state got valid=%b victim=%0d want 1111 1", valid4, victim4);
        end
    endtask

    task automatic test_flush;
        drive4(1'b1, 1'b1, 2'd3, 1'b1);
        checks++;
        if (gnt4 !== 1'b0 || evict4 !== 1'b0) begin
            errors++;
            $display("FAIL flush_gnt got gnt=%b ev=%b want 0 0", gnt4, evict4);
        end
        tick();
        checks++;
        if (valid4 !== 4'b0000 || victim4 !== 2'd1 || full4 !== 1'b0) begin
            errors++;
            $display("FAIL flush_state got valid=%b victim=%0d full=%b want 0000 1 0", valid4, victim4, full4);
        end
        drive4(1'b0, 1'b0, 2'd0, 1'b0);
    endtask

    task automatic test_five_slots;
        logic [2:0] exp_idx;
        @(negedge clk);
        rst5 = 1'b1;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            req5 = 1'b1;
            #1;
            exp_idx = (i < 5) ? 3'(i) : 3'((i - 5) % 5);
            checks++;
            if (gnt5 !== 1'b1 || idx5 !== exp_idx || evict5 !== (i >= 5)) begin
                errors++;
                $display("FAIL five_grant%0d got gnt=%b idx=%0d ev=%b want 1 %0d %b",
                         i, gnt5, idx5, evict5, exp_idx, (i >= 5));
            end
            tick();
        end
        checks++;
        if (valid5 !== 5'b11111 || victim5 !== 3'd1) begin
            errors++;
            $display("FAIL five_state got valid=%b victim=%0d want 11111 1", valid5, victim5);
        end
        @(negedge clk);
        #2;
        rst5 = 1'b0;
        #1;
        checks++;
        if ({gnt5, idx5, evict5, valid5, full5, victim5} !== 14'b0) begin
            errors++;
            $display("FAIL five_async_reset got gnt=%b idx=%0d ev=%b valid=%b full=%b victim=%0d want all 0",
                     gnt5, idx5, evict5, valid5, full5, victim5);
        end
        req5 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_evict_wrap();
        test_free_then_alloc();
        test_free_alloc_same_cycle();
        test_flush();
        test_five_slots();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
